// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: scalar typedefs, opcode
// constants, ALU operation classes and the FSM state encoding.
// Optional feature macro used by this slice: MCTRL_PERF_CNT_EN.
package multicycle_ctrl_pkg;

  typedef logic       u1;
  typedef logic [1:0] u2;
  typedef logic [2:0] u3;
  typedef logic [5:0] u6;

  localparam u6 OP_RTYPE = 6'b000000;
  localparam u6 OP_LW    = 6'b100011;
  localparam u6 OP_SW    = 6'b101011;
  localparam u6 OP_BEQ   = 6'b000100;
  localparam u6 OP_ADDI  = 6'b001000;
  localparam u6 OP_J     = 6'b000010;

  localparam u3 ALUOP_ADD   = 3'b000;
  localparam u3 ALUOP_SUB   = 3'b001;
  localparam u3 ALUOP_FUNCT = 3'b010;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle.
//   master: controller side (drives control strobes, illegal, state; reads op, mem_ready)
//   slave : datapath side (drives op, mem_ready; reads everything else)
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  u6          op;
  u1          mem_ready;
  u1          pcwrite;
  u1          branch;
  u1          iord;
  u1          memwrite;
  u1          irwrite;
  u1          regdst;
  u1          memtoreg;
  u1          regwrite;
  u1          alusrca;
  u2          alusrcb;
  u2          pcsrc;
  u3          aluop;
  u1          illegal;
  logic [3:0] state;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    output alusrca, alusrcb, pcsrc, aluop, illegal, state
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
    input  alusrca, alusrcb, pcsrc, aluop, illegal, state
  );

endinterface

// File: rtl/mctrl_outdec.sv
// Moore output decoder for the multicycle controller. Pure combinational.
// Inputs : state, mem_ready (mem_ready only gates the FETCH strobes)
// Outputs: all datapath control strobes/selects except illegal.
module mctrl_outdec
  import multicycle_ctrl_pkg::*;
(
  input  state_t state,
  input  u1      mem_ready,
  output u1      pcwrite,
  output u1      branch,
  output u1      iord,
  output u1      memwrite,
  output u1      irwrite,
  output u1      regdst,
  output u1      memtoreg,
  output u1      regwrite,
  output u1      alusrca,
  output u2      alusrcb,
  output u2      pcsrc,
  output u3      aluop
);

  always_comb begin
    pcwrite  = 1'b0;
    branch   = 1'b0;
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    pcsrc    = 2'b00;
    aluop    = ALUOP_ADD;
    case (state)
      StFetch: begin
        // PC+4 and IR load only commit on the cycle the fetch completes
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      StDecode: alusrcb = 2'b11;
      StMemAdr, StAddiExec: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      StMemRd: iord = 1'b1;
      StMemWr: begin
        iord     = 1'b1;
        memwrite = 1'b1;
      end
      StMemWb: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      StExecute: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      StAluWb: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      StBranch: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      StAddiWb: regwrite = 1'b1;
      StJump: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM: state register, next-state logic and the
// illegal-opcode pulse; output decode lives in mctrl_outdec.
// Ports: clk, reset (async, active-high), bus (multicycle_ctrl_if.master).
// Macro MCTRL_PERF_CNT_EN adds cycle_cnt / instret_cnt performance counters.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_ctrl_if.master       bus
`ifdef MCTRL_PERF_CNT_EN
  ,
  output logic [31:0]             cycle_cnt,
  output logic [31:0]             instret_cnt
`endif
);

  state_t state_q, state_d;
  u1      illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    case (state_q)
      StFetch:  if (bus.mem_ready) state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecute;
          OP_BEQ:       state_d = StBranch;
          OP_ADDI:      state_d = StAddiExec;
          OP_J:         state_d = StJump;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr:   state_d = (bus.op == OP_SW) ? StMemWr : StMemRd;
      StMemRd:    if (bus.mem_ready) state_d = StMemWb;
      StMemWr:    if (bus.mem_ready) state_d = StFetch;
      StExecute:  state_d = StAluWb;
      StAddiExec: state_d = StAddiWb;
      // Write-back, branch and jump states all retire back to fetch; so do
      // the unused encodings 12-15.
      default:    state_d = StFetch;
    endcase
  end

  assign bus.illegal = illegal;
  assign bus.state   = state_q;

  mctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.mem_ready),
    .pcwrite   (bus.pcwrite),
    .branch    (bus.branch),
    .iord      (bus.iord),
    .memwrite  (bus.memwrite),
    .irwrite   (bus.irwrite),
    .regdst    (bus.regdst),
    .memtoreg  (bus.memtoreg),
    .regwrite  (bus.regwrite),
    .alusrca   (bus.alusrca),
    .alusrcb   (bus.alusrcb),
    .pcsrc     (bus.pcsrc),
    .aluop     (bus.aluop)
  );

`ifdef MCTRL_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;
  u1           retire;

  // An instruction retires when it returns to FETCH from an execution state;
  // fetch stalls and illegal-opcode aborts from DECODE do not count.
  assign retire = (state_d == StFetch) && (state_q != StFetch) && (state_q != StDecode);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_q;
  assign instret_cnt = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  multicycle_ctrl_if bus ();

`ifdef MCTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  multicycle_ctrl u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MCTRL_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: pcwrite branch iord memwrite irwrite regdst memtoreg regwrite
  //            alusrca alusrcb[1:0] pcsrc[1:0] aluop[2:0]
  logic [15:0] ctrl;
  assign ctrl = {bus.pcwrite, bus.branch, bus.iord, bus.memwrite, bus.irwrite, bus.regdst,
                 bus.memtoreg, bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.aluop};

  localparam logic [15:0] C_FETCH   = 16'h8820;
  localparam logic [15:0] C_FETCH0  = 16'h0020;
  localparam logic [15:0] C_DECODE  = 16'h0060;
  localparam logic [15:0] C_MEMADR  = 16'h00C0;
  localparam logic [15:0] C_MEMRD   = 16'h2000;
  localparam logic [15:0] C_MEMWR   = 16'h3000;
  localparam logic [15:0] C_MEMWB   = 16'h0300;
  localparam logic [15:0] C_EXEC    = 16'h0082;
  localparam logic [15:0] C_ALUWB   = 16'h0500;
  localparam logic [15:0] C_BRANCH  = 16'h4089;
  localparam logic [15:0] C_ADDIEX  = 16'h00C0;
  localparam logic [15:0] C_ADDIWB  = 16'h0100;
  localparam logic [15:0] C_JUMP    = 16'h8010;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; return at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_st(input string tag, input logic [3:0] st, input logic [15:0] c);
    check({tag, " state"}, {28'd0, bus.state}, {28'd0, st});
    check({tag, " ctrl"}, {16'd0, ctrl}, {16'd0, c});
    check({tag, " illegal"}, {31'd0, bus.illegal}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = OP_LW;
    bus.mem_ready = 1'b1;
    tick();
    tick();

    // Reset holds FETCH with mem_ready gating visible
    expect_st("rst mr1", 4'd0, C_FETCH);
    bus.mem_ready = 1'b0;
    #1;
    expect_st("rst mr0", 4'd0, C_FETCH0);
`ifdef MCTRL_PERF_CNT_EN
    check("rst cycle_cnt", cycle_cnt, 32'd0);
    check("rst instret_cnt", instret_cnt, 32'd0);
`endif
    bus.mem_ready = 1'b1;
    reset         = 1'b0;
    #1;

`ifdef MCTRL_PERF_CNT_EN
    // RTYPE (4 cycles) then J (3 cycles): 7 cycles, 2 retirements
    bus.op = OP_RTYPE;
    tick(); tick(); tick(); tick();
    bus.op = OP_J;
    tick(); tick(); tick();
    check("perf cycle_cnt", cycle_cnt, 32'd7);
    check("perf instret_cnt", instret_cnt, 32'd2);
    check("perf state", {28'd0, bus.state}, 32'd0);
    bus.op = OP_LW;
    reset  = 1'b1;
    tick();
    reset  = 1'b0;
    #1;
`endif

    // LW: 0,1,2,3,4,0
    expect_st("lw f", 4'd0, C_FETCH);
    tick(); expect_st("lw dec", 4'd1, C_DECODE);
    tick(); expect_st("lw adr", 4'd2, C_MEMADR);
    tick(); expect_st("lw rd", 4'd3, C_MEMRD);
    tick(); expect_st("lw wb", 4'd4, C_MEMWB);
    tick(); expect_st("lw done", 4'd0, C_FETCH);

    // SW with 3 wait cycles in MEMWR: memwrite high for 4 cycles
    bus.op = OP_SW;
    tick(); expect_st("sw dec", 4'd1, C_DECODE);
    tick(); expect_st("sw adr", 4'd2, C_MEMADR);
    bus.mem_ready = 1'b0;
    tick(); expect_st("sw wr1", 4'd5, C_MEMWR);
    tick(); expect_st("sw wr2", 4'd5, C_MEMWR);
    tick(); expect_st("sw wr3", 4'd5, C_MEMWR);
    bus.mem_ready = 1'b1;
    #1;
    expect_st("sw wr4", 4'd5, C_MEMWR);
    tick(); expect_st("sw done", 4'd0, C_FETCH);

    // BEQ: 0,1,8,0
    bus.op = OP_BEQ;
    tick(); expect_st("beq dec", 4'd1, C_DECODE);
    tick(); expect_st("beq br", 4'd8, C_BRANCH);
    tick(); expect_st("beq done", 4'd0, C_FETCH);

    // RTYPE: 0,1,6,7,0
    bus.op = OP_RTYPE;
    tick(); expect_st("rt dec", 4'd1, C_DECODE);
    tick(); expect_st("rt ex", 4'd6, C_EXEC);
    tick(); expect_st("rt wb", 4'd7, C_ALUWB);
    tick(); expect_st("rt done", 4'd0, C_FETCH);

    // ADDI: 0,1,9,10,0
    bus.op = OP_ADDI;
    tick(); expect_st("addi dec", 4'd1, C_DECODE);
    tick(); expect_st("addi ex", 4'd9, C_ADDIEX);
    tick(); expect_st("addi wb", 4'd10, C_ADDIWB);
    tick(); expect_st("addi done", 4'd0, C_FETCH);

    // J: 0,1,11,0
    bus.op = OP_J;
    tick(); expect_st("j dec", 4'd1, C_DECODE);
    tick(); expect_st("j jump", 4'd11, C_JUMP);
    tick(); expect_st("j done", 4'd0, C_FETCH);

    // Illegal opcode 0x3F: one-cycle pulse in DECODE, back to FETCH
    bus.op = 6'h3F;
    tick();
    check("ill state", {28'd0, bus.state}, 32'd1);
    check("ill ctrl", {16'd0, ctrl}, {16'd0, C_DECODE});
    check("ill pulse", {31'd0, bus.illegal}, 32'd1);
    tick(); expect_st("ill done", 4'd0, C_FETCH);

    // Fetch stall: strobes gated, state holds
    bus.op        = OP_SW;
    bus.mem_ready = 1'b0;
    #1;
    expect_st("stall c0", 4'd0, C_FETCH0);
    tick(); expect_st("stall c1", 4'd0, C_FETCH0);
    bus.mem_ready = 1'b1;
    #1;

    // Reset during MEMWR drops memwrite before the next clock edge
    tick(); expect_st("rsw dec", 4'd1, C_DECODE);
    tick(); expect_st("rsw adr", 4'd2, C_MEMADR);
    bus.mem_ready = 1'b0;
    tick(); expect_st("rsw wr", 4'd5, C_MEMWR);
    reset = 1'b1;
    #1;
    check("rsw memwrite", {31'd0, bus.memwrite}, 32'd0);
    check("rsw state", {28'd0, bus.state}, 32'd0);
    check("rsw ctrl", {16'd0, ctrl}, {16'd0, C_FETCH0});
    tick();
    reset         = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    expect_st("post rst", 4'd0, C_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high; the ports are named clk and reset.
REQ-002 Port list (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- op  in  6  opcode from instruction register.
- mem_ready  in  1  memory completes this cycle.
- pcwrite  out  1  unconditional PC update.
- branch  out  1  conditional PC update (datapath ANDs with zero).
- iord  out  1  memory address select (0=PC, 1=ALUOut).
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regdst  out  1  write register select (1=rd).
- memtoreg  out  1  write-back data select (1=memory).
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select (1=register A).
- alusrcb  out  2  ALU B select (00 B, 01 const 4, 10 signimm, 11 signimm<<2).
- pcsrc  out  2  PC source (00 ALU, 01 ALUOut, 10 jump target).
- aluop  out  3  ALU operation class (ADD, SUB, FUNCT).
- illegal  out  1  one-cycle pulse on unsupported opcode.
- state  out  4  current state, for debug.

Function
REQ-003 The block SHALL implement a Moore FSM; all outputs except illegal are decoded from state and mem_ready only.
REQ-004 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL transition to FETCH.
REQ-005 FETCH: iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00; irwrite and pcwrite SHALL be asserted only while mem_ready=1. On mem_ready=1 go to DECODE, else hold.
REQ-006 DECODE: alusrca=0, alusrcb=11, aluop=ADD. Next state: LW/SW->MEMADR, RTYPE->EXECUTE, BEQ->BRANCH, ADDI->ADDIEXEC, J->JUMP. Any other opcode->FETCH, with illegal=1 for that cycle only.
REQ-007 MEMADR: alusrca=1, alusrcb=10, aluop=ADD; go to MEMRD for LW, or MEMWR for SW.
REQ-008 MEMRD: iord=1; hold until mem_ready=1, then go to MEMWB.
REQ-009 MEMWR: iord=1, memwrite=1 (held while waiting); hold until mem_ready=1, then go to FETCH.
REQ-010 MEMWB: regdst=0, memtoreg=1, regwrite=1; go to FETCH.
REQ-011 EXECUTE: alusrca=1, alusrcb=00, aluop=FUNCT; go to ALUWB. ALUWB: regdst=1, memtoreg=0, regwrite=1; go to FETCH.
REQ-012 BRANCH: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01, branch=1; go to FETCH.
REQ-013 ADDIEXEC: alusrca=1, alusrcb=10, aluop=ADD; go to ADDIWB. ADDIWB: regdst=0, memtoreg=0, regwrite=1; go to FETCH.
REQ-014 JUMP: pcsrc=10, pcwrite=1; go to FETCH.
REQ-015 Every output not listed for a state SHALL be 0; no output is ever X.
REQ-016 Instruction latency with mem_ready held at 1: LW 5 cycles; SW, RTYPE, ADDI 4 cycles; BEQ, J 3 cycles. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.

Reset
REQ-017 While reset=1, state SHALL be FETCH and illegal SHALL be 0. All outputs SHALL take their FETCH values with mem_ready gating applied.
REQ-018 Reset asserted mid-instruction SHALL abort that instruction immediately; a pending memwrite SHALL drop asynchronously.

Configuration
REQ-019 With MCTRL_PERF_CNT_EN defined, the block SHALL add two outputs: cycle_cnt[31:0], which increments every non-reset cycle, and instret_cnt[31:0], which increments on each transition into FETCH from any state other than FETCH or DECODE.
REQ-020 Both counters SHALL reset to 0 and wrap from 0xFFFFFFFF to 0.
REQ-021 Without MCTRL_PERF_CNT_EN, these ports and registers SHALL be absent.

Structure
REQ-022 The shared package SHALL hold the opcode constants, the state enum and the aluop encodings (ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_FUNCT=010), using the u1/u2/u3/u6 typedefs.
REQ-023 Output decode SHALL reside in one sub-module, mctrl_outdec (inputs state and mem_ready; pure combinational); the state register and next-state logic SHALL stay in multicycle_ctrl.

Verification
REQ-024 Reset release with mem_ready=1 and op=LW (100011) -> state sequence 0,1,2,3,4,0; regwrite=1 with memtoreg=1 only in state 4.
REQ-025 op=SW (101011) with mem_ready low for 3 cycles in MEMWR -> memwrite=1 for 4 consecutive cycles, then state=0.
REQ-026 op=BEQ (000100) -> state 8 shows branch=1, pcsrc=01, aluop=001 for exactly one cycle; total 3 cycles.
REQ-027 op=0x3F in DECODE -> illegal=1 for one cycle; next state 0; regwrite and memwrite never asserted.
REQ-028 mem_ready=0 in FETCH -> irwrite=0 and pcwrite=0, state stays 0; asserting reset in state 5 -> memwrite=0 before the next clock edge.
REQ-029 With MCTRL_PERF_CNT_EN defined, RTYPE then J -> after 7 cycles from reset release, cycle_cnt=7 and instret_cnt=2.
